// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic is_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: control inputs, instruction-memory port and decode handshake.
interface fetch_if;

    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc_current;
    logic [31:0] instruction;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc_plus4;
    logic        fetch_fault;

    modport master (
        input  stall, redirect_valid, redirect_target, instruction, dec_ready,
        output pc_current, dec_valid, dec_pc, dec_instr, dec_pc_plus4, fetch_fault
    );

    modport slave (
        output stall, redirect_valid, redirect_target, instruction, dec_ready,
        input  pc_current, dec_valid, dec_pc, dec_instr, dec_pc_plus4, fetch_fault
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, instr} pairs; synchronous flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    fetch_entry_t  mem_r [DEPTH];
    logic          full_s;
    logic          empty_s;
    logic          push_ok_s;
    logic          pop_ok_s;

    // A push into a full FIFO is only taken when the head leaves in the same cycle
    always_comb begin
        full_s    = (count_r == CW'(DEPTH));
        empty_s   = (count_r == {CW{1'b0}});
        push_ok_s = push && (!full_s || pop);
        pop_ok_s  = pop && !empty_s;
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, buffers fetched instructions and feeds decode,
// handling redirects, stall and misaligned-target faults.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input logic     clk,
    input logic     reset,
    fetch_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state_r;
    fetch_state_t  state_nxt_s;
    logic [31:0]   pc_r;
    logic [31:0]   pc_nxt_s;
    logic          fault_r;
    logic          fault_nxt_s;
    logic          push_s;
    logic          pop_s;
    logic          flush_s;
    logic          dec_valid_s;
    logic          full_s;
    logic          empty_s;
    logic [CW-1:0] count_s;
    fetch_entry_t  wdata_s;
    fetch_entry_t  head_s;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .wdata (wdata_s),
        .rdata (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Handshake arbitration: a redirect suppresses the push and flushes the buffer
    always_comb begin
        dec_valid_s   = (count_s != {CW{1'b0}});
        pop_s         = dec_valid_s && bus.dec_ready;
        flush_s       = bus.redirect_valid;
        push_s        = (state_r == FETCH) && !bus.stall && !bus.redirect_valid
                        && (!full_s || pop_s);
        wdata_s.pc    = pc_r;
        wdata_s.instr = bus.instruction;
    end

    // Next PC, state and fault; the faulting target is still loaded for debug
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        fault_nxt_s = fault_r;
        if (bus.redirect_valid) begin
            pc_nxt_s = bus.redirect_target;
            if (is_aligned(bus.redirect_target[1:0])) begin
                state_nxt_s = FETCH;
                fault_nxt_s = 1'b0;
            end else begin
                state_nxt_s = HALT;
                fault_nxt_s = 1'b1;
            end
        end else begin
            case (state_r)
                FETCH: begin
                    if (push_s) begin
                        pc_nxt_s = pc_r + PC_INCR;
                    end else begin
                        pc_nxt_s = pc_r;
                    end
                end
                HALT: begin
                    pc_nxt_s = pc_r;
                end
                default: begin
                    state_nxt_s = HALT;
                    fault_nxt_s = 1'b1;
                end
            endcase
        end
    end

    // PC, FSM state and sticky fault flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FETCH;
            pc_r    <= RESET_PC;
            fault_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            fault_r <= fault_nxt_s;
        end
    end

    assign bus.pc_current   = pc_r;
    assign bus.fetch_fault  = fault_r;
    assign bus.dec_valid    = dec_valid_s;
    assign bus.dec_pc       = empty_s ? 32'h0000_0000 : head_s.pc;
    assign bus.dec_instr    = empty_s ? 32'h0000_0000 : head_s.instr;
    assign bus.dec_pc_plus4 = empty_s ? 32'h0000_0000 : head_s.pc + PC_INCR;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front-end stage directly upstream of the instruction memory.
- Owns the program counter, drives `pc_current` to the instruction memory, and captures the returned 32-bit instruction combinationally.
- Buffers fetched {pc, instr} pairs in a small FIFO.
- Hands them to the decode stage with a valid/ready handshake; handles redirects (branch/jal/jalr), global stall and misaligned-target faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, fetch buffer entries (power of two, ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  freezes PC advance and FIFO pushes; pops still allowed.
- redirect_valid  in  1  one-cycle request to change the fetch PC.
- redirect_target  in  32  new PC when redirect_valid=1.
- pc_current  out  32  fetch address to the instruction memory (PC register).
- instruction  in  32  instruction word at pc_current (combinational memory read).
- dec_valid  out  1  FIFO head valid.
- dec_ready  in  1  decode accepts the head this cycle.
- dec_pc  out  32  PC of head entry.
- dec_instr  out  32  instruction of head entry.
- dec_pc_plus4  out  32  dec_pc + 4 (mod 2^32).
- fetch_fault  out  1  sticky misaligned-redirect flag.

Behaviour:
- Reset (asynchronous, immediate):
  - pc_current=RESET_PC, FIFO count=0, dec_valid=0.
  - dec_pc, dec_instr and dec_pc_plus4 read 0.
  - fetch_fault=0, state=FETCH.
- States:
  - FETCH: normal fetch.
  - HALT: fault; no pushes, PC frozen.
- pop = dec_valid & dec_ready.
- push, in FETCH only, when all hold: !stall, !redirect_valid, and (count<FIFO_DEPTH or pop).
  - Writes {pc_current, instruction}.
  - pc_current <= pc_current+4, wrapping at 2^32 with no flag.
- Simultaneous push and pop at full: legal; count unchanged; FIFO order preserved.
- Latency: an instruction presented at pc_current in cycle N appears on dec_* in cycle N+1 if the FIFO was empty.
  - Back-to-back throughput is 1 instruction/cycle while dec_ready=1.
- Full with no pop: no push; PC holds; instruction input ignored.
- dec_* stable while dec_valid=1 and dec_ready=0.
- Redirect (highest priority, any state):
  - FIFO flushed (count=0 next cycle); no push that cycle.
  - A pop in the same cycle counts as accepted (it is the redirecting instruction), then everything is discarded.
  - pc_current <= redirect_target.
  - If redirect_target[1:0]==0: state=FETCH, fetch_fault<=0.
  - If redirect_target[1:0]!=0: state=HALT, fetch_fault<=1. pc_current still loads the target, for debug.
- HALT: dec_valid=0 after the flush; remains until an aligned redirect.
- stall and redirect together: redirect wins.
- stall does not block pops, so the FIFO drains normally.
- Reset mid-operation: all state cleared asynchronously; the first push occurs on the first clk edge after reset deasserts (if !stall).
- Widths: all PC arithmetic is 32-bit unsigned modulo; the instruction memory indexes pc_current[9:2].

Decomposition:
- Package fetch_pkg:
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}
  - enum fetch_state_t {FETCH, HALT}
  - localparam PC_INCR=32'd4
  - default RESET_PC
- Sub-module fetch_fifo:
  - Parameterized depth.
  - Ports: push, pop, flush, wdata/rdata as fetch_entry_t, count, full, empty.
  - Synchronous flush, asynchronous reset.
- fetch_unit holds the PC register, FSM, fault flag, and push/pop/redirect arbitration.

Test Plan:
- Streaming: release reset with dec_ready=1, stall=0, memory holding 00100093, 00200113, 00308193.
  - Cycle 1: dec_valid=1, dec_pc=0, dec_instr=00100093, dec_pc_plus4=4.
  - Cycle 2: dec_pc=4, dec_instr=00200113.
  - Cycle 3: dec_pc=8.
- Backpressure: hold dec_ready=0 for 4 cycles from reset.
  - FIFO fills with PC 0,4; pc_current holds at 8; dec_pc stays 0.
  - Raise dec_ready: entries emerge in order 0, 4, 8 with no gaps or duplicates.
- Redirect: while streaming, pulse redirect_valid with target 32'h24.
  - Next cycle: count=0, dec_valid=0, pc_current=24.
  - Following cycle: dec_pc=24, dec_instr=memory[9]=0080006f.
- Misaligned redirect: pulse target 32'h2A.
  - fetch_fault=1, dec_valid=0, pc_current=2A, frozen for 10 cycles.
  - Aligned redirect to 32'h28: fault clears; dec_instr=00140463 one cycle later.
- Stall + redirect priority:
  - Assert stall for 3 cycles: pc_current constant; FIFO drains to empty.
  - Redirect during stall to 32'h10: pc_current=10 next cycle; no push until stall drops.
  - Then dec_pc=10, dec_instr=00510293.
- Async reset mid-stream: assert reset between edges with the FIFO full.
  - Outputs go immediately to pc_current=0, dec_valid=0, fetch_fault=0.
  - Normal streaming from PC 0 resumes after release.
